fifo_insert_arbiter: RTL and testbench



---
 rtl/fifo_insert_arbiter_pkg.sv | 9 +
 rtl/fifo_insert_arbiter_fifo.sv | 50 +++++
 rtl/fifo_insert_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_insert_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_insert_arbiter_pkg.sv
// Shared encodings and types for the multi-producer Fifo insert arbiter.
package fifo_insert_arbiter_pkg;

   typedef logic [0:0] arb_state_t;

   localparam arb_state_t ARB_IDLE   = 1'b0;
   localparam arb_state_t ARB_LOCKED = 1'b1;

endpackage

// File: rtl/fifo_insert_arbiter_fifo.sv
// Circular-buffer Fifo; one slot is kept free so full and empty are distinguishable.
module fifo_insert_arbiter_fifo #(
   parameter int unsigned DATA_SIZE_END = 63,
   parameter int unsigned DEPTH_BITS    = 3
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   insert_value_i,
   input  logic                   pop_value_i,
   input  logic [DATA_SIZE_END:0] in_value_i,
   output logic [DATA_SIZE_END:0] out_value_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int unsigned Depth = 2 ** DEPTH_BITS;

   logic [DATA_SIZE_END:0]  mem_q [Depth];
   logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
   logic                    do_push, do_pop;

   always_comb begin
      empty_o  = (wr_ptr_q == rd_ptr_q);
      full_o   = ((wr_ptr_q + DEPTH_BITS'(1)) == rd_ptr_q);
      do_push  = insert_value_i & ~full_o;
      do_pop   = pop_value_i & ~empty_o;
      wr_ptr_d = do_push ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= in_value_i;
      end
   end

   assign out_value_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_insert_arbiter.sv
// Round-robin insert arbiter with burst lock in front of a shared Fifo, plus occupancy count.
module fifo_insert_arbiter
   import fifo_insert_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_SIZE_END = 63,
   parameter int unsigned DEPTH_BITS    = 3
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [NUM_REQ-1:0]                 req_i,
   input  logic [NUM_REQ-1:0]                 req_last_i,
   input  logic [NUM_REQ*(DATA_SIZE_END+1)-1:0] req_data_i,
   output logic [NUM_REQ-1:0]                 grant_o,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [DATA_SIZE_END:0]             out_data_o,
   output logic                               full_o,
   output logic [DEPTH_BITS-1:0]              count_o
);

   localparam int unsigned W    = DATA_SIZE_END + 1;
   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
   localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NUM_REQ);

   arb_state_t            state_q, state_d;
   logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]       owner_q, owner_d;
   logic [DEPTH_BITS-1:0] count_q, count_d;

   logic [2*NUM_REQ-1:0]  req_rot;
   logic [IdxW-1:0]       off;
   logic [IdxW:0]         win_sum;
   logic [IdxW-1:0]       win_idx;
   logic                  found;
   logic [IdxW-1:0]       grant_idx;
   logic                  insert;
   logic                  pop;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [W-1:0]          in_data;

   function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
      if (idx == LastIdx) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // First requester at or after rr_ptr_q, modulo NUM_REQ.
   always_comb begin
      req_rot = {req_i, req_i} >> rr_ptr_q;
      found   = 1'b0;
      off     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            off   = IdxW'(i);
         end
      end
      win_sum = {1'b0, rr_ptr_q} + {1'b0, off};
      if (win_sum >= NumReqW) begin
         win_sum = win_sum - NumReqW;
      end
      win_idx = win_sum[IdxW-1:0];
   end

   always_comb begin
      grant_o   = '0;
      grant_idx = (state_q == ARB_LOCKED) ? owner_q : win_idx;
      if (!reset_i && !fifo_full) begin
         if (state_q == ARB_IDLE) begin
            if (found) begin
               grant_o[win_idx] = 1'b1;
            end
         end else if (req_i[owner_q]) begin
            grant_o[owner_q] = 1'b1;
         end
      end
      insert = |grant_o;
   end

   always_comb begin
      in_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_o[i]) begin
            in_data = req_data_i[i*W +: W];
         end
      end
   end

   assign out_valid_o = ~fifo_empty;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      if (insert) begin
         if (state_q == ARB_IDLE) begin
            if (req_last_i[grant_idx]) begin
               rr_ptr_d = wrap_inc(grant_idx);
            end else begin
               owner_d = grant_idx;
               state_d = ARB_LOCKED;
            end
         end else if (req_last_i[owner_q]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = wrap_inc(owner_q);
         end
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({insert, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = fifo_full;

   fifo_insert_arbiter_fifo #(
      .DATA_SIZE_END (DATA_SIZE_END),
      .DEPTH_BITS    (DEPTH_BITS)
   ) u_fifo (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .insert_value_i (insert),
      .pop_value_i    (pop),
      .in_value_i     (in_data),
      .out_value_o    (out_data_o),
      .empty_o        (fifo_empty),
      .full_o         (fifo_full)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert ($onehot0(grant_o));
         assert (!(insert && fifo_full));
      end
   end

endmodule

// File: tb/tb_fifo_insert_arbiter.sv
// Bench: fixed vector table, hand-written corner sequences and a random run against a queue model.
module tb_fifo_insert_arbiter;

   localparam int unsigned NReq      = 4;
   localparam int unsigned W         = 64;
   localparam int unsigned DepthBits = 3;
   localparam int          Cap       = 7;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NReq-1:0]      req, req_last, grant;
   logic [NReq*W-1:0]    req_data;
   logic                 out_valid, out_ready, full;
   logic [W-1:0]         out_data;
   logic [DepthBits-1:0] count;

   fifo_insert_arbiter #(
      .NUM_REQ       (NReq),
      .DATA_SIZE_END (W - 1),
      .DEPTH_BITS    (DepthBits)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_i       (req),
      .req_last_i  (req_last),
      .req_data_i  (req_data),
      .grant_o     (grant),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .full_o      (full),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: the queue contents plus round-robin and lock bookkeeping.
   logic [W-1:0] mq[$];
   int           rr     = 0;
   int           own    = 0;
   bit           locked = 1'b0;

   typedef struct {
      logic [3:0] rq;
      logic [3:0] lst;
      logic       rdy;
      logic [3:0] eg;
      int         ec;
      logic       ev;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_grant(input logic [3:0] rq);
      logic [3:0] g;
      int         k;
      g = '0;
      if (mq.size() >= Cap) return g;
      if (locked) begin
         if (rq[own]) g[own] = 1'b1;
         return g;
      end
      for (int i = 0; i < NReq; i++) begin
         k = (rr + i) % NReq;
         if (rq[k]) begin
            g[k] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   // Drive one cycle's inputs, compare at the falling edge, then advance the model at the edge.
   task automatic step(input logic [3:0] rq, input logic [3:0] lst, input logic rdy,
                       input logic rst, input logic [63:0] dfix, input bit use_exp,
                       input logic [3:0] eg, input int ec, input logic ev, input string nm);
      logic [3:0] mg;
      int         k;
      req       = rq;
      req_last  = lst;
      out_ready = rdy;
      reset     = rst;
      for (int i = 0; i < NReq; i++) begin
         req_data[i*W +: W] = (dfix != 0) ? dfix : {$urandom, $urandom};
      end
      @(negedge clk);
      mg = rst ? 4'b0 : model_grant(rq);
      chk({nm, ".grant"}, 64'(grant), 64'(mg));
      chk({nm, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
      chk({nm, ".count"}, 64'(count), 64'(mq.size()));
      chk({nm, ".full"}, 64'(full), 64'(mq.size() == Cap));
      if (mq.size() != 0) chk({nm, ".data"}, out_data, mq[0]);
      if (use_exp) begin
         chk({nm, ".tgrant"}, 64'(grant), 64'(eg));
         chk({nm, ".tcount"}, 64'(count), 64'(ec));
         chk({nm, ".tvalid"}, 64'(out_valid), 64'(ev));
      end
      if (rst) begin
         mq.delete();
         rr     = 0;
         own    = 0;
         locked = 1'b0;
      end else begin
         if (mq.size() != 0 && rdy) void'(mq.pop_front());
         if (mg != 0) begin
            k = 0;
            for (int i = 0; i < NReq; i++) if (mg[i]) k = i;
            mq.push_back(req_data[k*W +: W]);
            if (!locked) begin
               if (lst[k]) rr = (k + 1) % NReq;
               else begin
                  locked = 1'b1;
                  own    = k;
               end
            end else if (lst[k]) begin
               locked = 1'b0;
               rr     = (k + 1) % NReq;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(4'b0000, 4'b1111, 1'b0, 1'b1, 64'd0, 1'b0, 4'b0, 0, 1'b0, "rst");
   endtask

   initial begin
      logic [3:0] rq, lst;
      logic       rdy, rst;

      // Round-robin, then burst lock of producer 2 followed by producer 3.
      tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 0, 1'b0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1, 1'b1};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1, 1'b1};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1, 1'b1};
      tbl[5]  = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 1, 1'b1};
      tbl[6]  = '{4'b1111, 4'b1011, 1'b1, 4'b0100, 1, 1'b1};
      tbl[7]  = '{4'b1111, 4'b1011, 1'b1, 4'b0100, 1, 1'b1};
      tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1, 1'b1};
      tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1, 1'b1};
      tbl[10] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1, 1'b1};
      tbl[11] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 0, 1'b0};

      reset     = 1'b1;
      req       = '0;
      req_last  = '1;
      out_ready = 1'b0;
      req_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      mq.delete();

      do_reset();
      chk("post_reset.count", 64'(count), 64'd0);
      chk("post_reset.valid", 64'(out_valid), 64'd0);
      chk("post_reset.full", 64'(full), 64'd0);

      foreach (tbl[i]) begin
         step(tbl[i].rq, tbl[i].lst, tbl[i].rdy, 1'b0, 64'd0, 1'b1,
              tbl[i].eg, tbl[i].ec, tbl[i].ev, $sformatf("tbl%0d", i));
      end

      // Fill to capacity from producer 0 with the consumer stalled.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(4'b0001, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, (i < Cap) ? 4'b0001 : 4'b0000,
              (i < Cap) ? i : Cap, i > 0, $sformatf("fill%0d", i));
      end
      chk("fill.full", 64'(full), 64'd1);

      // Pop while full: no insert that cycle, then producer 1 gets in.
      step(4'b0010, 4'b1111, 1'b1, 1'b0, 64'd0, 1'b1, 4'b0000, 7, 1'b1, "fullpop0");
      step(4'b0010, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0010, 6, 1'b1, "fullpop1");
      step(4'b0000, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0000, 7, 1'b1, "fullpop2");

      // Empty pass-through latency.
      do_reset();
      step(4'b0100, 4'b1111, 1'b0, 1'b0, 64'hDEADBEEF, 1'b1, 4'b0100, 0, 1'b0, "pass0");
      chk("pass.head", out_data, 64'hDEADBEEF);
      step(4'b0000, 4'b1111, 1'b1, 1'b0, 64'd0, 1'b1, 4'b0000, 1, 1'b1, "pass1");
      step(4'b0000, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0000, 0, 1'b0, "pass2");

      // Reset while producer 1 holds the lock with two items queued.
      do_reset();
      step(4'b0010, 4'b0000, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0010, 0, 1'b0, "rmb0");
      step(4'b0010, 4'b0000, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0010, 1, 1'b1, "rmb1");
      step(4'b1000, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0000, 2, 1'b1, "rmb_stall");
      step(4'b1010, 4'b1111, 1'b0, 1'b1, 64'd0, 1'b1, 4'b0000, 2, 1'b1, "rmb_rst");
      step(4'b1000, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b1000, 0, 1'b0, "rmb_after");
      step(4'b0000, 4'b1111, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0000, 1, 1'b1, "rmb_q");

      // Random traffic against the model; consumer rate varies between phases.
      for (int i = 0; i < 1500; i++) begin
         rq  = 4'($urandom_range(0, 15));
         lst = 4'($urandom | $urandom);
         rdy = ($urandom_range(0, 99) < ((i < 750) ? 30 : 80));
         rst = ($urandom_range(0, 199) == 0);
         step(rq, lst, rdy, rst, 64'd0, 1'b0, 4'b0, 0, 1'b0, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
